// File: rtl/e_mult_div.sv
// Execute-stage multiply/divide unit with private HI/LO registers.
// Results are computed at start and committed after a fixed busy window.
module e_mult_div #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MD_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);
    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    state_e      state;
    logic [31:0] cnt;
    logic [63:0] tmp;
    logic        div_zero;
    logic [31:0] hi_q, lo_q;

    logic [63:0] res;
    logic        res_div_zero;
    logic [31:0] res_cycles;
    logic [63:0] prod_s, prod_u;
    logic [31:0] q_s, r_s;
    logic        div_ovf;

    assign prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u  = {32'b0, A} * {32'b0, B};
    // The one signed quotient that does not fit in 32 bits wraps to the dividend.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        q_s = '0;
        r_s = '0;
        if (div_ovf) begin
            q_s = 32'h8000_0000;
        end else if (B != '0) begin
            q_s = $signed(A) / $signed(B);
            r_s = $signed(A) % $signed(B);
        end
    end

    always_comb begin
        res          = '0;
        res_div_zero = 1'b0;
        res_cycles   = 32'(MULT_CYCLES);
        case (MD_Op)
            OpMult:  res = prod_s;
            OpMultu: res = prod_u;
            OpDiv: begin
                res          = {r_s, q_s};
                res_div_zero = (B == '0);
                res_cycles   = 32'(DIV_CYCLES);
            end
            OpDivu: begin
                if (B != '0) res = {A % B, A / B};
                res_div_zero = (B == '0);
                res_cycles   = 32'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    assign Busy   = (state == StRun);
    assign Start  = (MD_Op >= OpMult) && (MD_Op <= OpDivu) && !Busy;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MD_Out = (MD_Op == OpMfhi) ? hi_q :
                    (MD_Op == OpMflo) ? lo_q : 32'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            cnt      <= '0;
            tmp      <= '0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (Start) begin
                        tmp      <= res;
                        cnt      <= res_cycles;
                        div_zero <= res_div_zero;
                        state    <= StRun;
                    end else if (MD_Op == OpMthi) begin
                        hi_q <= A;
                    end else if (MD_Op == OpMtlo) begin
                        lo_q <= A;
                    end
                end
                StRun: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        // Divide-by-zero leaves HI/LO as they were.
                        if (!div_zero) begin
                            hi_q <= tmp[63:32];
                            lo_q <= tmp[31:0];
                        end
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_e_mult_div.sv
// Scoreboard bench for e_mult_div: stimulus pushes expected HI/LO and busy length,
// a negedge monitor checks them when Busy drops.
module tb_e_mult_div;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MD_Op;
    logic [31:0] A, B;
    logic        Start, Busy;
    logic [31:0] HI, LO, MD_Out;

    e_mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MD_Op(MD_Op), .A(A), .B(B),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MD_Out(MD_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: measure each busy window and compare the committed result.
    int busy_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (Busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'(busy_cnt), 32'd0);
            end else begin
                e = sb.pop_front();
                if (reset !== 1'b1) begin
                    check("sb_hi", HI, e.hi);
                    check("sb_lo", LO, e.lo);
                    check("sb_busy_len", 32'(busy_cnt), 32'(e.cycles));
                end
            end
            busy_cnt = 0;
        end
    end

    // Reference model: plain wide arithmetic on the architectural rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp, sq, sr;
        logic [63:0] w;
        e.cycles = (op <= 4'd2) ? MC : DC;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                w  = 64'(sp);
                m_hi = w[63:32]; m_lo = w[31:0];
            end
            4'd2: begin
                w = {32'b0, a} * {32'b0, b};
                m_hi = w[63:32]; m_lo = w[31:0];
            end
            4'd3: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) - sq * longint'($signed(b));
                m_lo = 32'(sq); m_hi = 32'(sr);
            end
            4'd4: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("busy_timeout", {31'b0, Busy}, 32'd0);
    endtask

    // Called at posedge+1; drives op this cycle, returns once idle again.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MD_Op = op; A = a; B = b;
        #0 check("start_on_issue", {31'b0, Start}, 32'd1);
        model(op, a, b);
        @(posedge clk); #1;
        MD_Op = 4'd0;
        wait_idle();
    endtask

    task automatic move_to(input logic is_hi, input logic [31:0] a);
        MD_Op = is_hi ? 4'd7 : 4'd8; A = a;
        @(posedge clk); #1;
        MD_Op = 4'd0;
        if (is_hi) m_hi = a; else m_lo = a;
        check(is_hi ? "mthi" : "mtlo", is_hi ? HI : LO, a);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b1; MD_Op = 4'd1; A = '0; B = '0;
        #12;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_start", {31'b0, Start}, 32'd1);
        MD_Op = 4'd5;
        #1 check("rst_mdout", MD_Out, 32'd0);
        MD_Op = 4'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        issue(4'd3, -32'sd7, 32'd2);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd2);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        move_to(1'b1, 32'h1234);
        move_to(1'b0, 32'h5678);
        issue(4'd3, 32'd5, 32'd0);
        check("dz_hi", HI, 32'h1234);
        check("dz_lo", LO, 32'h5678);

        move_to(1'b0, 32'hDEAD_BEEF);
        MD_Op = 4'd6;
        #1 check("mflo", MD_Out, 32'hDEAD_BEEF);
        MD_Op = 4'd5;
        #1 check("mfhi", MD_Out, 32'h1234);
        MD_Op = 4'd0;
        #1 check("mf_none", MD_Out, 32'd0);
        @(posedge clk); #1;

        // Ops presented mid-run must be ignored.
        MD_Op = 4'd1; A = 32'd3; B = 32'd4;
        model(4'd1, 32'd3, 32'd4);
        @(posedge clk); #1;
        MD_Op = 4'd8; A = 32'hAAAA;
        @(posedge clk); #1;
        MD_Op = 4'd1; A = 32'd9; B = 32'd9;
        #0 check("start_while_busy", {31'b0, Start}, 32'd0);
        @(posedge clk); #1;
        MD_Op = 4'd0;
        wait_idle();
        check("ignore_lo", LO, 32'd12);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            if (op <= 4'd4) issue(op, a, b);
            else move_to(op == 4'd5, a);
        end

        // Reset during run cycle 3 discards the in-flight divide.
        MD_Op = 4'd3; A = 32'd100; B = 32'd7;
        model(4'd3, 32'd100, 32'd7);
        @(posedge clk); #1;
        MD_Op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, Busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        MD_Op = 4'd5;
        #1 check("post_rst_mfhi", MD_Out, 32'd0);
        MD_Op = 4'd6;
        #1 check("post_rst_mflo", MD_Out, 32'd0);
        MD_Op = 4'd0;
        repeat (3) @(posedge clk);
        #1 check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
